// File: rtl/ocm_arb_pkg.sv
// Shared types and constants for the on-chip RAM port arbiter.
package ocm_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_M0   = 2'd1,
    OWN_M1   = 2'd2
  } owner_t;

  localparam int DEF_ADDR_W = 15;
  localparam int DEF_DATA_W = 32;
  localparam int RAM_RD_LAT = 1;

  function automatic owner_t owner_of(input logic sel_m1);
    return sel_m1 ? OWN_M1 : OWN_M0;
  endfunction

endpackage

// File: rtl/ocm_arb_rr2.sv
// Two-way round-robin grant with lock mask; last_gnt encoding is 0 = m0, 1 = m1.
module ocm_arb_rr2
  import ocm_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_gnt_i,
  input  owner_t     lock_own_i,
  output logic [1:0] gnt_o,
  output logic       last_gnt_o
);

  // Grant selection: a lock owner masks the other master completely.
  always_comb begin
    gnt_o      = 2'b00;
    last_gnt_o = last_gnt_i;
    case (lock_own_i)
      OWN_M0:  gnt_o = {1'b0, req_i[0]};
      OWN_M1:  gnt_o = {req_i[1], 1'b0};
      default: begin
        if (req_i == 2'b11) begin
          gnt_o = last_gnt_i ? 2'b01 : 2'b10;
        end else begin
          gnt_o = req_i;
        end
      end
    endcase
    if (gnt_o[1]) begin
      last_gnt_o = 1'b1;
    end else if (gnt_o[0]) begin
      last_gnt_o = 1'b0;
    end else begin
      last_gnt_o = last_gnt_i;
    end
  end

endmodule

// File: rtl/ocm_port_arbiter.sv
// Two-master Avalon-MM arbiter in front of a single-port on-chip RAM.
// Optional access counters are enabled with the macro OCM_ARB_ACCESS_COUNTERS_EN.
module ocm_port_arbiter
  import ocm_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int RD_LAT = RAM_RD_LAT,
  parameter int CNT_W  = 32
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  input  logic [DATA_W-1:0]   m0_writedata,
  input  logic                m0_lock,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_readdatavalid,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  input  logic [DATA_W-1:0]   m1_writedata,
  input  logic                m1_lock,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_readdatavalid,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic [DATA_W-1:0]   mem_writedata,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic                mem_clken,
  input  logic [DATA_W-1:0]   mem_readdata
`ifdef OCM_ARB_ACCESS_COUNTERS_EN
  , input  logic             cnt_clear
  , output logic [CNT_W-1:0] m0_rd_cnt
  , output logic [CNT_W-1:0] m0_wr_cnt
  , output logic [CNT_W-1:0] m1_rd_cnt
  , output logic [CNT_W-1:0] m1_wr_cnt
`endif
);

  if (RD_LAT != RAM_RD_LAT) begin : g_rd_lat_check
    $error("ocm_port_arbiter: only RD_LAT = 1 is supported");
  end

  logic [1:0] req_s;
  logic [1:0] gnt_s;
  logic       last_gnt_q, last_gnt_d;
  owner_t     lock_own_q, lock_own_d;
  logic       rd_pend_q, rd_pend_d;
  logic       rd_own_q, rd_own_d;
  logic [1:0] rd_acc_s;
  logic [1:0] wr_acc_s;

  // Requests are masked while in reset so nothing is granted.
  assign req_s = {(m1_read | m1_write), (m0_read | m0_write)} & {2{reset_n}};

  ocm_arb_rr2 u_rr2 (
    .req_i      (req_s),
    .last_gnt_i (last_gnt_q),
    .lock_own_i (lock_own_q),
    .gnt_o      (gnt_s),
    .last_gnt_o (last_gnt_d)
  );

  assign wr_acc_s = gnt_s & {m1_write, m0_write};
  assign rd_acc_s = gnt_s & {m1_read & ~m1_write, m0_read & ~m0_write};

  // Lock FSM: IDLE (OWN_NONE) <-> LOCKED_M0 / LOCKED_M1, never directly between owners.
  always_comb begin
    lock_own_d = lock_own_q;
    case (lock_own_q)
      OWN_NONE: begin
        if (gnt_s[0] && m0_lock) begin
          lock_own_d = OWN_M0;
        end else if (gnt_s[1] && m1_lock) begin
          lock_own_d = OWN_M1;
        end else begin
          lock_own_d = OWN_NONE;
        end
      end
      OWN_M0: begin
        if (gnt_s[0] && !m0_lock) begin
          lock_own_d = OWN_NONE;
        end else begin
          lock_own_d = OWN_M0;
        end
      end
      OWN_M1: begin
        if (gnt_s[1] && !m1_lock) begin
          lock_own_d = OWN_NONE;
        end else begin
          lock_own_d = OWN_M1;
        end
      end
      default: lock_own_d = OWN_NONE;
    endcase
  end

  assign rd_pend_d = |rd_acc_s;
  assign rd_own_d  = rd_acc_s[1];

  // Arbitration and read-return state.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      last_gnt_q <= 1'b1;
      lock_own_q <= OWN_NONE;
      rd_pend_q  <= 1'b0;
      rd_own_q   <= 1'b0;
    end else begin
      last_gnt_q <= last_gnt_d;
      lock_own_q <= lock_own_d;
      rd_pend_q  <= rd_pend_d;
      rd_own_q   <= rd_own_d;
    end
  end

  assign m0_waitrequest = ~gnt_s[0];
  assign m1_waitrequest = ~gnt_s[1];

  // With no grant the mux rests on m0; chipselect/write stay low.
  assign mem_address    = gnt_s[1] ? m1_address    : m0_address;
  assign mem_byteenable = gnt_s[1] ? m1_byteenable : m0_byteenable;
  assign mem_writedata  = gnt_s[1] ? m1_writedata  : m0_writedata;
  assign mem_chipselect = |gnt_s;
  assign mem_write      = |wr_acc_s;
  assign mem_clken      = reset_n;

  assign m0_readdata      = mem_readdata;
  assign m1_readdata      = mem_readdata;
  assign m0_readdatavalid = reset_n & rd_pend_q & ~rd_own_q;
  assign m1_readdatavalid = reset_n & rd_pend_q &  rd_own_q;

`ifdef OCM_ARB_ACCESS_COUNTERS_EN
  logic [CNT_W-1:0] cnt_q [4];
  logic [CNT_W-1:0] cnt_d [4];
  logic [3:0]       cnt_ev_s;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  assign cnt_ev_s = {wr_acc_s[1], rd_acc_s[1], wr_acc_s[0], rd_acc_s[0]};

  // Saturating counter next-state; clear beats increment.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      cnt_d[k] = cnt_q[k];
      if (cnt_clear) begin
        cnt_d[k] = {CNT_W{1'b0}};
      end else if (cnt_ev_s[k]) begin
        cnt_d[k] = sat_inc(cnt_q[k]);
      end else begin
        cnt_d[k] = cnt_q[k];
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (!reset_n) begin
        cnt_q[k] <= {CNT_W{1'b0}};
      end else begin
        cnt_q[k] <= cnt_d[k];
      end
    end
  end

  assign m0_rd_cnt = cnt_q[0];
  assign m0_wr_cnt = cnt_q[1];
  assign m1_rd_cnt = cnt_q[2];
  assign m1_wr_cnt = cnt_q[3];
`endif

endmodule

// File: tb/tb_ocm_port_arbiter.sv
// Randomized and directed bench for ocm_port_arbiter against a behavioural model.
module tb_ocm_port_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [14:0] m0_address, m1_address;
  logic        m0_read, m0_write, m0_lock, m1_read, m1_write, m1_lock;
  logic [3:0]  m0_byteenable, m1_byteenable;
  logic [31:0] m0_writedata, m1_writedata;
  logic        m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
  logic [31:0] m0_readdata, m1_readdata;
  logic [14:0] mem_address;
  logic [3:0]  mem_byteenable;
  logic [31:0] mem_writedata, mem_readdata;
  logic        mem_chipselect, mem_write, mem_clken;
`ifdef OCM_ARB_ACCESS_COUNTERS_EN
  logic        cnt_clear;
  logic [3:0]  m0_rd_cnt, m0_wr_cnt, m1_rd_cnt, m1_wr_cnt;
  int          mcnt [4];
`endif

  always #5 clk = ~clk;

  ocm_port_arbiter #(.CNT_W(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_byteenable(m0_byteenable), .m0_writedata(m0_writedata), .m0_lock(m0_lock),
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_byteenable(m1_byteenable), .m1_writedata(m1_writedata), .m1_lock(m1_lock),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable), .mem_writedata(mem_writedata),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write), .mem_clken(mem_clken),
    .mem_readdata(mem_readdata)
`ifdef OCM_ARB_ACCESS_COUNTERS_EN
    , .cnt_clear(cnt_clear), .m0_rd_cnt(m0_rd_cnt), .m0_wr_cnt(m0_wr_cnt)
    , .m1_rd_cnt(m1_rd_cnt), .m1_wr_cnt(m1_wr_cnt)
`endif
  );

  // RAM behind the arbiter: 1-cycle registered read, byte-lane writes.
  logic [31:0] ram [0:32767];
  always @(posedge clk) begin
    if (mem_chipselect && mem_clken) begin
      if (mem_write) begin
        for (int k = 0; k < 4; k++)
          if (mem_byteenable[k]) ram[mem_address][8*k +: 8] <= mem_writedata[8*k +: 8];
      end else begin
        mem_readdata <= ram[mem_address];
      end
    end
  end

  // Reference model state
  logic [31:0] shadow [0:32767];
  int          last_m, lock_m, pend_own;
  bit          pend;
  logic [31:0] pend_data;
  int          tests, fails;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic idle();
    m0_read = 1'b0; m0_write = 1'b0; m0_lock = 1'b0;
    m1_read = 1'b0; m1_write = 1'b0; m1_lock = 1'b0;
  endtask

  task automatic drive(input int m, input bit rd, input bit wr, input bit lk,
                       input logic [14:0] a, input logic [3:0] be, input logic [31:0] d);
    if (m == 0) begin
      m0_read = rd; m0_write = wr; m0_lock = lk; m0_address = a; m0_byteenable = be; m0_writedata = d;
    end else begin
      m1_read = rd; m1_write = wr; m1_lock = lk; m1_address = a; m1_byteenable = be; m1_writedata = d;
    end
  endtask

  // One clock cycle: predict, compare at negedge, then advance the model.
  task automatic cycle();
    int          g;
    bit          q0, q1, gw, gr, gl;
    logic [14:0] ga;
    logic [3:0]  gbe;
    logic [31:0] gd;
    @(negedge clk);
    q0 = m0_read | m0_write;
    q1 = m1_read | m1_write;
    g  = -1;
    if (reset_n) begin
      if (lock_m == 1)      g = q0 ? 0 : -1;
      else if (lock_m == 2) g = q1 ? 1 : -1;
      else if (q0 && q1)    g = (last_m == 0) ? 1 : 0;
      else if (q0)          g = 0;
      else if (q1)          g = 1;
    end
    gw  = (g == 1) ? m1_write : m0_write;
    gr  = (g == 1) ? m1_read : m0_read;
    gl  = (g == 1) ? m1_lock : m0_lock;
    ga  = (g == 1) ? m1_address : m0_address;
    gbe = (g == 1) ? m1_byteenable : m0_byteenable;
    gd  = (g == 1) ? m1_writedata : m0_writedata;
    check_eq("m0_waitrequest", 32'(m0_waitrequest), 32'(g != 0));
    check_eq("m1_waitrequest", 32'(m1_waitrequest), 32'(g != 1));
    check_eq("m0_readdatavalid", 32'(m0_readdatavalid), 32'(reset_n && pend && pend_own == 0));
    check_eq("m1_readdatavalid", 32'(m1_readdatavalid), 32'(reset_n && pend && pend_own == 1));
    if (reset_n && pend) begin
      check_eq("m0_readdata", m0_readdata, pend_data);
      check_eq("m1_readdata", m1_readdata, pend_data);
    end
    check_eq("mem_chipselect", 32'(mem_chipselect), 32'(g >= 0));
    check_eq("mem_write", 32'(mem_write), 32'(g >= 0 && gw));
    check_eq("mem_clken", 32'(mem_clken), 32'(reset_n));
    if (g >= 0) check_eq("mem_address", 32'(mem_address), 32'(ga));
`ifdef OCM_ARB_ACCESS_COUNTERS_EN
    check_eq("m0_rd_cnt", 32'(m0_rd_cnt), 32'(mcnt[0]));
    check_eq("m0_wr_cnt", 32'(m0_wr_cnt), 32'(mcnt[1]));
    check_eq("m1_rd_cnt", 32'(m1_rd_cnt), 32'(mcnt[2]));
    check_eq("m1_wr_cnt", 32'(m1_wr_cnt), 32'(mcnt[3]));
    for (int k = 0; k < 4; k++) begin
      if (!reset_n || cnt_clear) mcnt[k] = 0;
      else if (g >= 0 && k == 2*g + (gw ? 1 : 0) && mcnt[k] < 15) mcnt[k]++;
    end
`endif
    if (!reset_n) begin
      last_m = 1; lock_m = 0; pend = 1'b0;
    end else begin
      pend = (g >= 0) && gr && !gw;
      pend_own = g;
      pend_data = shadow[ga];
      if (g >= 0) begin
        last_m = g;
        if (gl) lock_m = g + 1;
        else if (lock_m == g + 1) lock_m = 0;
        if (gw)
          for (int k = 0; k < 4; k++)
            if (gbe[k]) shadow[ga][8*k +: 8] = gd[8*k +: 8];
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests = 0; fails = 0;
    last_m = 1; lock_m = 0; pend = 1'b0; pend_own = 0; pend_data = 32'h0;
    for (int i = 0; i < 32768; i++) begin
      ram[i]    = 32'hA500_0000 ^ i;
      shadow[i] = 32'hA500_0000 ^ i;
    end
    reset_n = 1'b0;
    idle();
    drive(0, 1'b0, 1'b0, 1'b0, 15'h0, 4'hF, 32'h0);
    drive(1, 1'b0, 1'b0, 1'b0, 15'h0, 4'hF, 32'h0);
`ifdef OCM_ARB_ACCESS_COUNTERS_EN
    cnt_clear = 1'b0;
    for (int k = 0; k < 4; k++) mcnt[k] = 0;
`endif
    @(posedge clk); #1;
    m0_read = 1'b1; m1_read = 1'b1;
    cycle(); cycle();
    reset_n = 1'b1; idle();

    // Write then read back from m0
    drive(0, 1'b0, 1'b1, 1'b0, 15'h0010, 4'hF, 32'hDEADBEEF); cycle();
    drive(0, 1'b1, 1'b0, 1'b0, 15'h0010, 4'hF, 32'h0);        cycle();
    idle(); cycle();

    // Contended reads alternate
    drive(0, 1'b1, 1'b0, 1'b0, 15'h0010, 4'hF, 32'h0);
    drive(1, 1'b1, 1'b0, 1'b0, 15'h0020, 4'hF, 32'h0);
    repeat (4) cycle();
    idle(); cycle();

    // m1 locked RMW while m0 requests continuously
    drive(0, 1'b1, 1'b0, 1'b0, 15'h0030, 4'hF, 32'h0); cycle();
    drive(1, 1'b1, 1'b0, 1'b1, 15'h0020, 4'hF, 32'h0); cycle();
    drive(1, 1'b0, 1'b1, 1'b0, 15'h0020, 4'hF, 32'h1111_2222); cycle();
    drive(1, 1'b0, 1'b0, 1'b0, 15'h0020, 4'hF, 32'h0); cycle();
    idle(); cycle();

    // Byte enables at the top address
    drive(0, 1'b0, 1'b1, 1'b0, 15'h7FFF, 4'hF, 32'hFFFF_FFFF); cycle();
    drive(0, 1'b0, 1'b1, 1'b0, 15'h7FFF, 4'h3, 32'h1234_5678); cycle();
    drive(0, 1'b1, 1'b0, 1'b0, 15'h7FFF, 4'hF, 32'h0);         cycle();
    idle(); cycle();

    // Reset right after an accepted m1 read
    drive(1, 1'b1, 1'b0, 1'b0, 15'h0010, 4'hF, 32'h0); cycle();
    idle(); reset_n = 1'b0; cycle();
    reset_n = 1'b1;
    drive(0, 1'b1, 1'b0, 1'b0, 15'h0010, 4'hF, 32'h0);
    drive(1, 1'b1, 1'b0, 1'b0, 15'h0020, 4'hF, 32'h0);
    cycle(); cycle();
    idle(); cycle();

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      reset_n = ($urandom_range(0, 299) != 0);
      for (int m = 0; m < 2; m++) begin
        logic [14:0] a;
        a = ($urandom_range(0, 3) == 0) ? 15'h7FFF : 15'($urandom_range(0, 15));
        drive(m, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 7) == 0), a, 4'($urandom), $urandom);
      end
`ifdef OCM_ARB_ACCESS_COUNTERS_EN
      cnt_clear = ($urandom_range(0, 63) == 0);
`endif
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
